sccb_init_sequencer: RTL and testbench

Sequences the SCCB master through camera bring-up. It first reads and checks the sensor product ID, then walks an external register-init table of {sub_addr, data} pairs and issues one SCCB write per entry. Table entries can also request millisecond delays or end the sequence. The block sits between the system-control logic (go/busy/status) and the SCCB master core, and replaces ad-hoc per-register state machines.

---
 rtl/sccb_init_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_sccb_init_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_init_sequencer.sv
// Camera bring-up sequencer: checks the sensor product ID over SCCB, then replays
// a {sub_addr, data} init table as SCCB writes, with inline ms delays and end marker.
module sccb_init_sequencer #(
  parameter logic [7:0] WRITE_ID    = 8'h42,
  parameter logic [7:0] READ_ID     = 8'h43,
  parameter logic [7:0] ID_REG      = 8'h0A,
  parameter logic [7:0] ID_VAL      = 8'h76,
  parameter int         ROM_AW      = 8,
  parameter int         CLK_PER_MS  = 8000,
  parameter int         TIMEOUT_CYC = 2000000
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              go,
  output logic              busy,
  output logic              init_done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [7:0]        id_read,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_start,
  output logic              sccb_rw,
  output logic [7:0]        sccb_ip_addr,
  output logic [7:0]        sccb_sub_addr,
  output logic [7:0]        sccb_data_in,
  input  logic [7:0]        sccb_data_out,
  input  logic              sccb_done
);

  localparam int CNT_MAX = (TIMEOUT_CYC > CLK_PER_MS) ? TIMEOUT_CYC : CLK_PER_MS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [ROM_AW-1:0] ADDR_LAST = '1;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ID_REQ  = 4'd1;
  localparam logic [3:0] S_ID_WAIT = 4'd2;
  localparam logic [3:0] S_ID_REL  = 4'd3;
  localparam logic [3:0] S_FETCH   = 4'd4;
  localparam logic [3:0] S_DECODE  = 4'd5;
  localparam logic [3:0] S_WR_WAIT = 4'd6;
  localparam logic [3:0] S_WR_REL  = 4'd7;
  localparam logic [3:0] S_DELAY   = 4'd8;
  localparam logic [3:0] S_DONE    = 4'd9;
  localparam logic [3:0] S_ERROR   = 4'd10;

  logic [3:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        ms_q, ms_d;
  logic              busy_q, busy_d, init_done_q, init_done_d, error_q, error_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        id_read_q, id_read_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic              start_q, start_d, rw_q, rw_d;
  logic [7:0]        ip_q, ip_d, sub_q, sub_d, wdata_q, wdata_d;
  logic              adv, fail, tmo;
  logic [1:0]        fail_code;

  assign tmo = (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ms_d        = ms_q;
    busy_d      = busy_q;
    init_done_d = init_done_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    id_read_d   = id_read_q;
    rom_addr_d  = rom_addr_q;
    start_d     = start_q;
    rw_d        = rw_q;
    ip_d        = ip_q;
    sub_d       = sub_q;
    wdata_d     = wdata_q;
    adv         = 1'b0;
    fail        = 1'b0;
    fail_code   = 2'd0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (go) begin
          state_d     = S_ID_REQ;
          init_done_d = 1'b0;
          error_d     = 1'b0;
          err_code_d  = 2'd0;
          rom_addr_d  = '0;
          busy_d      = 1'b1;
        end
      end
      S_ID_REQ: begin
        ip_d    = READ_ID;
        sub_d   = ID_REG;
        rw_d    = 1'b1;
        start_d = 1'b1;
        state_d = S_ID_WAIT;
      end
      // sccb_done is checked before the timeout so a late completion still counts
      S_ID_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (sccb_done) begin
          id_read_d = sccb_data_out;
          start_d   = 1'b0;
          state_d   = S_ID_REL;
        end else if (tmo) begin
          fail = 1'b1; fail_code = 2'd2;
        end
      end
      S_ID_REL: begin
        cnt_d = cnt_q + CW'(1);
        if (!sccb_done) begin
          if (id_read_q == ID_VAL) state_d = S_FETCH;
          else begin fail = 1'b1; fail_code = 2'd1; end
        end else if (tmo) begin
          fail = 1'b1; fail_code = 2'd2;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (rom_data == 16'hFFFF) begin
          state_d     = S_DONE;
          init_done_d = 1'b1;
          busy_d      = 1'b0;
        end else if (rom_data[15:8] == 8'hF0) begin
          if (rom_data[7:0] == 8'd0) adv = 1'b1;
          else begin
            ms_d    = rom_data[7:0];
            state_d = S_DELAY;
          end
        end else begin
          ip_d    = WRITE_ID;
          sub_d   = rom_data[15:8];
          wdata_d = rom_data[7:0];
          rw_d    = 1'b0;
          start_d = 1'b1;
          state_d = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (sccb_done) begin
          start_d = 1'b0;
          state_d = S_WR_REL;
        end else if (tmo) begin
          fail = 1'b1; fail_code = 2'd2;
        end
      end
      S_WR_REL: begin
        cnt_d = cnt_q + CW'(1);
        if (!sccb_done) adv = 1'b1;
        else if (tmo) begin fail = 1'b1; fail_code = 2'd2; end
      end
      // cnt_q counts cycles within the current ms; ms_q counts remaining ms
      S_DELAY: begin
        if (cnt_q == CW'(CLK_PER_MS - 1)) begin
          cnt_d = '0;
          if (ms_q == 8'd1) adv = 1'b1;
          else ms_d = ms_q - 8'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (adv) begin
      if (rom_addr_q == ADDR_LAST) begin
        fail = 1'b1; fail_code = 2'd3;
      end else begin
        rom_addr_d = rom_addr_q + ROM_AW'(1);
        state_d    = S_FETCH;
      end
    end
    if (fail) begin
      state_d    = S_ERROR;
      error_d    = 1'b1;
      busy_d     = 1'b0;
      err_code_d = fail_code;
      start_d    = 1'b0;
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ms_q        <= '0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= '0;
      id_read_q   <= '0;
      rom_addr_q  <= '0;
      start_q     <= 1'b0;
      rw_q        <= 1'b0;
      ip_q        <= '0;
      sub_q       <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ms_q        <= ms_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      id_read_q   <= id_read_d;
      rom_addr_q  <= rom_addr_d;
      start_q     <= start_d;
      rw_q        <= rw_d;
      ip_q        <= ip_d;
      sub_q       <= sub_d;
      wdata_q     <= wdata_d;
    end
  end

  assign busy          = busy_q;
  assign init_done     = init_done_q;
  assign error         = error_q;
  assign err_code      = err_code_q;
  assign id_read       = id_read_q;
  assign rom_addr      = rom_addr_q;
  assign sccb_start    = start_q;
  assign sccb_rw       = rw_q;
  assign sccb_ip_addr  = ip_q;
  assign sccb_sub_addr = sub_q;
  assign sccb_data_in  = wdata_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Bench for sccb_init_sequencer: table-driven model of expected SCCB transactions,
// outcome and delay cost, plus a randomised SCCB slave and ROM.
module tb_sccb_init_sequencer;
  localparam int AW = 2, DEPTH = 4, CPM = 10, TMO = 100;

  logic PCLK = 1'b0, PRESETN = 1'b0, go = 1'b0, sccb_done = 1'b0;
  logic [15:0] rom_data = '0;
  logic [7:0]  sccb_data_out = '0;
  logic busy, init_done, error, sccb_start, sccb_rw;
  logic [1:0] err_code;
  logic [7:0] id_read, sccb_ip_addr, sccb_sub_addr, sccb_data_in;
  logic [AW-1:0] rom_addr;

  sccb_init_sequencer #(.ROM_AW(AW), .CLK_PER_MS(CPM), .TIMEOUT_CYC(TMO)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .go(go), .busy(busy), .init_done(init_done),
    .error(error), .err_code(err_code), .id_read(id_read), .rom_addr(rom_addr),
    .rom_data(rom_data), .sccb_start(sccb_start), .sccb_rw(sccb_rw),
    .sccb_ip_addr(sccb_ip_addr), .sccb_sub_addr(sccb_sub_addr),
    .sccb_data_in(sccb_data_in), .sccb_data_out(sccb_data_out), .sccb_done(sccb_done));

  always #5 PCLK = ~PCLK;

  typedef struct packed {logic rw; logic [7:0] ip; logic [7:0] sub; logic [7:0] data; logic [AW-1:0] idx;} txn_t;
  txn_t exp_q[$];
  logic [15:0] rom [DEPTH];
  int total = 0, bad = 0, last_hi = 0;
  logic respond = 1'b1;
  int fixed_lat = 0, fixed_hold = 0;
  logic [7:0] id_resp = 8'h76;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ROM: data reflects the address presented one cycle earlier
  initial begin
    logic [AW-1:0] a;
    forever begin
      @(negedge PCLK) a = rom_addr;
      @(posedge PCLK); #1 rom_data = rom[a];
    end
  end

  // SCCB slave: random latency to done, done held 1-3 cycles
  initial begin
    int lat, hold;
    bit pend, rwc;
    pend = 0; lat = 0; hold = 0; rwc = 0;
    forever begin
      @(posedge PCLK); #1;
      if (!PRESETN) begin pend = 0; sccb_done = 1'b0; continue; end
      if (sccb_done) begin
        hold--;
        if (hold <= 0) begin sccb_done = 1'b0; pend = 0; end
      end else if (pend) begin
        if (!sccb_start) pend = 0;
        else if (respond) begin
          lat--;
          if (lat <= 0) begin
            sccb_done = 1'b1;
            sccb_data_out = rwc ? id_resp : 8'($urandom);
            hold = (fixed_hold > 0) ? fixed_hold : int'($urandom_range(1, 3));
          end
        end
      end else if (sccb_start) begin
        pend = 1; rwc = sccb_rw;
        lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
      end
    end
  end

  // Compare process: every transaction against the expected queue, every cycle
  initial begin
    txn_t cur;
    int low, hi_len;
    bit prev;
    cur = '0; low = 100; hi_len = 0; prev = 0;
    forever begin
      @(negedge PCLK);
      if (!PRESETN) begin low = 100; hi_len = 0; prev = 0; continue; end
      if (sccb_start && !prev) begin
        chk("txn_gap_ge3", 32'(low >= 3), 1);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_txn: got rw=%0d sub=%0h want none", sccb_rw, sccb_sub_addr);
          cur = '0;
        end else cur = exp_q.pop_front();
        hi_len = 0;
      end
      if (sccb_start) begin
        hi_len++;
        chk("txn_rw", 32'(sccb_rw), 32'(cur.rw));
        chk("txn_ip", 32'(sccb_ip_addr), 32'(cur.ip));
        chk("txn_sub", 32'(sccb_sub_addr), 32'(cur.sub));
        if (!cur.rw) chk("txn_data", 32'(sccb_data_in), 32'(cur.data));
        chk("txn_rom_addr", 32'(rom_addr), 32'(cur.idx));
        chk("busy_in_txn", 32'(busy), 1);
        low = 0;
      end else begin
        if (prev) last_hi = hi_len;
        low++;
      end
      chk("busy_vs_status", 32'(busy && (init_done || error)), 0);
      prev = sccb_start;
    end
  end

  task automatic push_txn(input logic rw, input logic [7:0] ip, input logic [7:0] sub,
                          input logic [7:0] data, input logic [AW-1:0] idx);
    txn_t t;
    t.rw = rw; t.ip = ip; t.sub = sub; t.data = data; t.idx = idx;
    exp_q.push_back(t);
  endtask

  // Model: walk the table as the sequencer must, producing txns, outcome and delay cost
  task automatic plan(input logic [7:0] idv, output bit e_err, output logic [1:0] e_code,
                      output logic [AW-1:0] e_addr, output int extra);
    bit ended;
    e_err = 0; e_code = 0; e_addr = 0; extra = 0; ended = 0;
    push_txn(1'b1, 8'h43, 8'h0A, 8'h00, '0);
    if (!respond) begin e_err = 1; e_code = 2; return; end
    if (idv != 8'h76) begin e_err = 1; e_code = 1; return; end
    for (int i = 0; i < DEPTH && !ended; i++) begin
      if (rom[i] == 16'hFFFF) begin e_addr = AW'(i); ended = 1; end
      else if (rom[i][15:8] == 8'hF0) extra += 2 + int'(rom[i][7:0]) * CPM;
      else push_txn(1'b0, 8'h42, rom[i][15:8], rom[i][7:0], AW'(i));
    end
    if (!ended) begin e_err = 1; e_code = 3; e_addr = AW'(DEPTH - 1); end
  endtask

  task automatic run(input string tag, input logic [7:0] idv, input int mid_go,
                     output int cycles, output int extra);
    bit e_err; logic [1:0] e_code; logic [AW-1:0] e_addr;
    plan(idv, e_err, e_code, e_addr, extra);
    id_resp = idv;
    @(posedge PCLK); #1 go = 1'b1;
    @(posedge PCLK); #1 go = 1'b0;
    chk({tag, "_go_busy"}, 32'(busy), 1);
    chk({tag, "_go_clr"}, 32'({init_done, error, err_code}), 0);
    cycles = 0;
    while (!(init_done || error) && cycles < 3000) begin
      @(posedge PCLK); #1;
      go = (cycles == mid_go && mid_go > 0);
      cycles++;
    end
    go = 1'b0;
    if (cycles >= 3000) begin total++; bad++; $display("FAIL %s_wait: got no finish want finish", tag); end
    @(negedge PCLK); #1;
    chk({tag, "_init_done"}, 32'(init_done), 32'(!e_err));
    chk({tag, "_error"}, 32'(error), 32'(e_err));
    chk({tag, "_err_code"}, 32'(err_code), 32'(e_code));
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'(e_addr));
    chk({tag, "_busy_end"}, 32'(busy), 0);
    chk({tag, "_start_end"}, 32'(sccb_start), 0);
    if (respond) chk({tag, "_id_read"}, 32'(id_read), 32'(idv));
    chk({tag, "_txns_left"}, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  initial begin
    int c, ca, cb, cc, ex, kind;
    logic [7:0] idv;
    #12;
    chk("rst_outputs", 32'({busy, init_done, error, err_code, id_read, rom_addr, sccb_start, sccb_rw}), 0);
    chk("rst_addr_bus", 32'({sccb_ip_addr, sccb_sub_addr, sccb_data_in}), 0);
    @(negedge PCLK) PRESETN = 1'b1;

    // ID read answered after 50 cycles, then two writes and end marker
    fixed_lat = 50;
    rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF; rom[3] = 16'h0000;
    run("two_wr", 8'h76, 0, c, ex);
    chk("two_wr_id_lit", 32'(id_read), 32'h76);
    chk("two_wr_addr_lit", 32'(rom_addr), 2);
    fixed_lat = 0;

    run("id_bad", 8'h73, 0, c, ex);
    chk("id_bad_code_lit", 32'(err_code), 1);

    // Delay cost measured against a bare end-marker table
    fixed_lat = 5; fixed_hold = 1;
    rom[0] = 16'hFFFF;
    run("dly_base", 8'h76, 0, ca, ex);
    rom[0] = 16'hF002; rom[1] = 16'hFFFF;
    run("dly_2ms", 8'h76, 0, cb, ex);
    chk("dly_2ms_model", 32'(cb - ca), 32'(ex));
    chk("dly_2ms_lit", 32'(cb - ca), 22);
    rom[0] = 16'hF000; rom[1] = 16'hF002; rom[2] = 16'hFFFF;
    run("dly_zero", 8'h76, 0, cc, ex);
    chk("dly_zero_lit", 32'(cc - ca), 24);
    chk("dly_zero_done_addr", 32'(rom_addr), 2);
    fixed_lat = 0; fixed_hold = 0;

    // Slave never answers: timeout, then recovery on next go
    respond = 1'b0;
    run("tmo", 8'h76, 0, c, ex);
    chk("tmo_start_len", 32'(last_hi), TMO);
    respond = 1'b1;
    rom[0] = 16'h3A04; rom[1] = 16'hFFFF;
    run("tmo_recover", 8'h76, 0, c, ex);

    // go while busy must not restart the sequence
    fixed_lat = 20;
    rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
    run("go_busy", 8'h76, 5, c, ex);

    // Async reset while a write is outstanding
    begin
      bit e_err; logic [1:0] e_code; logic [AW-1:0] e_addr;
      plan(8'h76, e_err, e_code, e_addr, ex);
      @(posedge PCLK); #1 go = 1'b1;
      @(posedge PCLK); #1 go = 1'b0;
      c = 0;
      while (!(sccb_start && !sccb_rw) && c < 500) begin @(posedge PCLK); #1; c++; end
      chk("rst_wr_reached", 32'(c < 500), 1);
      @(negedge PCLK); PRESETN = 1'b0; #1;
      chk("rst_mid_outputs", 32'({busy, init_done, error, err_code, id_read, rom_addr, sccb_start, sccb_rw}), 0);
      chk("rst_mid_bus", 32'({sccb_ip_addr, sccb_sub_addr, sccb_data_in}), 0);
      exp_q.delete();
      repeat (2) @(negedge PCLK);
      PRESETN = 1'b1;
    end
    fixed_lat = 0;

    // Table with no end marker
    rom[0] = 16'h0101; rom[1] = 16'h0202; rom[2] = 16'hF001; rom[3] = 16'h0404;
    run("overrun", 8'h76, 0, c, ex);
    chk("overrun_code_lit", 32'(err_code), 3);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        kind = int'($urandom_range(0, 9));
        if (kind < 6) rom[i] = {8'($urandom_range(0, 8'hEF)), 8'($urandom)};
        else if (kind < 8) rom[i] = {8'hF0, 8'($urandom_range(0, 2))};
        else rom[i] = 16'hFFFF;
      end
      idv = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h76;
      run("rand", idv, 0, c, ex);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
